// File: rtl/audio_in_hit_detector_pkg.sv
// Shared definitions for the mic hit detector: state encodings, datapath widths, magnitude helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package audio_in_hit_detector_pkg;

    localparam int ENV_W     = 32;
    localparam int LEVEL_MSB = 30;
    localparam int LEVEL_LSB = 27;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_MAG  = 2'd2,
        S_ENV  = 2'd3
    } sample_state_t;

    typedef enum logic {
        H_ARMED = 1'b0,
        H_HOLD  = 1'b1
    } hit_state_t;

    // Absolute value of a signed 32-bit sample; the most negative code has no positive
    // twin, so it is clamped to the largest positive value to keep the result below 2^31.
    function automatic logic [ENV_W-1:0] abs_sat(input logic [ENV_W-1:0] x);
        logic [ENV_W-1:0] r;
        if (x == 32'h8000_0000) begin
            r = 32'h7FFF_FFFF;
        end else if (x[ENV_W-1]) begin
            r = (~x) + 32'd1;
        end else begin
            r = x;
        end
        return r;
    endfunction

endpackage

// File: rtl/audio_in_hit_detector_hit_holdoff_fsm.sv
// Strike detector: compares the envelope with a selectable threshold, then holds off re-firing.
// Latency: hit is combinational with sample_valid (same cycle).
// Backpressure: none; advances only when sample_valid pulses.
module hit_holdoff_fsm
    import audio_in_hit_detector_pkg::*;
#(
    parameter int THRESH_SHIFT    = 24,
    parameter int HOLDOFF_SAMPLES = 4800
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [ENV_W-1:0] env,
    input  logic [3:0]       thresh_sel,
    output logic             hit
);

    localparam logic [15:0] HOLDOFF_LOAD = 16'(HOLDOFF_SAMPLES - 1);

    hit_state_t       state;
    hit_state_t       state_nxt;
    logic [15:0]      cnt;
    logic [15:0]      cnt_nxt;
    logic [ENV_W-1:0] thresh_hi;
    logic [ENV_W-1:0] thresh_lo;

    // Re-arm level sits at half the firing level so a ringing strike does not chatter.
    assign thresh_hi = {28'd0, thresh_sel} << THRESH_SHIFT;
    assign thresh_lo = thresh_hi >> 1;

    // State and holdoff counter registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= H_ARMED;
            cnt   <= 16'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, holdoff countdown and the hit pulse; nothing moves between samples.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hit       = 1'b0;
        if (sample_valid && !reset) begin
            case (state)
                H_ARMED: begin
                    if ((thresh_sel != 4'd0) && (env >= thresh_hi)) begin
                        hit       = 1'b1;
                        cnt_nxt   = HOLDOFF_LOAD;
                        state_nxt = H_HOLD;
                    end
                end
                H_HOLD: begin
                    if (cnt != 16'd0) begin
                        cnt_nxt = cnt - 16'd1;
                    end else if (env < thresh_lo) begin
                        state_nxt = H_ARMED;
                    end
                end
                default: state_nxt = H_ARMED;
            endcase
        end
    end

endmodule

// File: rtl/audio_in_hit_detector.sv
// Pops ADC FIFO samples, forms a magnitude, tracks a peak-hold/decay envelope, flags strikes.
// Latency: 4 cycles per sample; sample_valid follows the pop cycle by 3 cycles.
// Backpressure: pops only from S_IDLE when audio_in_available=1; at most one pop per pass.
module audio_in_hit_detector
    import audio_in_hit_detector_pkg::*;
#(
    parameter int DECAY_SHIFT     = 6,
    parameter int THRESH_SHIFT    = 24,
    parameter int HOLDOFF_SAMPLES = 4800,
    parameter int USE_RIGHT       = 0
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             audio_in_available,
    input  logic [31:0]      left_channel_audio_in,
    input  logic [31:0]      right_channel_audio_in,
    input  logic [3:0]       thresh_sel,
    output logic             read_audio_in,
    output logic             sample_valid,
    output logic [ENV_W-1:0] envelope,
    output logic [3:0]       level,
    output logic             hit
);

    sample_state_t    state;
    sample_state_t    state_nxt;
    logic [31:0]      left_q;
    logic [31:0]      right_q;
    logic [ENV_W-1:0] abs_l;
    logic [ENV_W-1:0] abs_r;
    logic [ENV_W-1:0] mag_nxt;
    logic [ENV_W-1:0] mag_q;
    logic [ENV_W-1:0] env_nxt;
    logic [ENV_W-1:0] env_q;
    logic             sample_valid_q;

    // Sample FSM state register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sample FSM sequencing; availability is only looked at in S_IDLE because the FIFO
    // flag can lag a pop by a cycle. The pop is masked during reset so nothing is lost.
    always_comb begin
        state_nxt     = state;
        read_audio_in = 1'b0;
        case (state)
            S_IDLE: if (audio_in_available) state_nxt = S_POP;
            S_POP: begin
                read_audio_in = !reset;
                state_nxt     = S_MAG;
            end
            S_MAG:   state_nxt = S_ENV;
            S_ENV:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Magnitude of the latched sample; the right-channel mix halves both terms so the sum
    // stays below 2^31.
    always_comb begin
        abs_l = abs_sat(left_q);
        abs_r = abs_sat(right_q);
        if (USE_RIGHT != 0) begin
            mag_nxt = (abs_l >> 1) + (abs_r >> 1);
        end else begin
            mag_nxt = abs_l;
        end
    end

    // Peak-hold with proportional decay; once env>>DECAY_SHIFT reaches zero the value holds.
    always_comb begin
        if (mag_q > env_q) begin
            env_nxt = mag_q;
        end else begin
            env_nxt = env_q - (env_q >> DECAY_SHIFT);
        end
    end

    // Datapath registers: sample latch on pop, magnitude, envelope and its valid pulse.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            left_q         <= 32'd0;
            right_q        <= 32'd0;
            mag_q          <= '0;
            env_q          <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            sample_valid_q <= (state == S_ENV);
            if (state == S_POP) begin
                left_q  <= left_channel_audio_in;
                right_q <= right_channel_audio_in;
            end
            if (state == S_MAG) begin
                mag_q <= mag_nxt;
            end
            if (state == S_ENV) begin
                env_q <= env_nxt;
            end
        end
    end

    assign sample_valid = sample_valid_q;
    assign envelope     = env_q;
    assign level        = env_q[LEVEL_MSB:LEVEL_LSB];

    hit_holdoff_fsm #(
        .THRESH_SHIFT    (THRESH_SHIFT),
        .HOLDOFF_SAMPLES (HOLDOFF_SAMPLES)
    ) u_hit_holdoff_fsm (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .sample_valid (sample_valid_q),
        .env          (env_q),
        .thresh_sel   (thresh_sel),
        .hit          (hit)
    );

endmodule

// File: tb/tb_audio_in_hit_detector.sv
// Bench: two detectors (left-only and L/R mix) fed from one lagging-flag FIFO model in lockstep.
// Expected envelope/hit per sample is queued at push time; a monitor checks on sample_valid.
// Directed checks cover reset, saturation, decay, threshold, holdoff and pop pacing.
module tb_audio_in_hit_detector;

    localparam int HOLDOFF = 4800;
    localparam int DSH     = 6;
    localparam int TSH     = 24;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        audio_in_available;
    logic [31:0] left_channel_audio_in;
    logic [31:0] right_channel_audio_in;
    logic [3:0]  thresh_sel;
    logic        rd0, sv0, hit0, rd1, sv1, hit1;
    logic [31:0] env0, env1;
    logic [3:0]  lvl0, lvl1;

    always #10 CLOCK_50 = ~CLOCK_50;

    audio_in_hit_detector #(.DECAY_SHIFT(DSH), .THRESH_SHIFT(TSH),
                            .HOLDOFF_SAMPLES(HOLDOFF), .USE_RIGHT(0)) u_dut0 (
        .CLOCK_50(CLOCK_50), .reset(reset), .audio_in_available(audio_in_available),
        .left_channel_audio_in(left_channel_audio_in),
        .right_channel_audio_in(right_channel_audio_in), .thresh_sel(thresh_sel),
        .read_audio_in(rd0), .sample_valid(sv0), .envelope(env0), .level(lvl0), .hit(hit0));

    audio_in_hit_detector #(.DECAY_SHIFT(DSH), .THRESH_SHIFT(TSH),
                            .HOLDOFF_SAMPLES(HOLDOFF), .USE_RIGHT(1)) u_dut1 (
        .CLOCK_50(CLOCK_50), .reset(reset), .audio_in_available(audio_in_available),
        .left_channel_audio_in(left_channel_audio_in),
        .right_channel_audio_in(right_channel_audio_in), .thresh_sel(thresh_sel),
        .read_audio_in(rd1), .sample_valid(sv1), .envelope(env1), .level(lvl1), .hit(hit1));

    typedef struct { logic [31:0] l; logic [31:0] r; } smp_t;
    typedef struct { logic [31:0] env; logic hit; } exp_t;

    smp_t fifo[$];
    exp_t exp0[$];
    exp_t exp1[$];

    int n_vec = 0, n_err = 0;
    int cyc = 0, pops = 0, svs = 0, hits0 = 0, hits1 = 0;
    int last_pop = -100, sv_idx = 0, hit_idx = -1;
    logic pop_pend = 1'b0, flag_q = 1'b0, decr_mode = 1'b0;
    logic [31:0] prev_env = 32'd0;

    logic [31:0] m_env [2];
    logic        m_hold [2];
    int          m_cnt [2];

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, need %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mabs(input logic [31:0] x);
        if (x == 32'h8000_0000) return 32'h7FFF_FFFF;
        return x[31] ? (32'd0 - x) : x;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_env[k]  = 32'd0;
            m_hold[k] = 1'b0;
            m_cnt[k]  = 0;
        end
    endtask

    // Queue one sample and the response each detector must give for it.
    task automatic push(input logic [31:0] l, input logic [31:0] r);
        smp_t s;
        exp_t e;
        logic [31:0] mag, hi;
        s.l = l;
        s.r = r;
        fifo.push_back(s);
        hi = {28'd0, thresh_sel} << TSH;
        for (int k = 0; k < 2; k++) begin
            mag = (k == 0) ? mabs(l) : ((mabs(l) >> 1) + (mabs(r) >> 1));
            if (mag > m_env[k]) m_env[k] = mag;
            else                m_env[k] = m_env[k] - (m_env[k] >> DSH);
            e.env = m_env[k];
            e.hit = 1'b0;
            if (!m_hold[k]) begin
                if (thresh_sel != 4'd0 && m_env[k] >= hi) begin
                    e.hit     = 1'b1;
                    m_hold[k] = 1'b1;
                    m_cnt[k]  = HOLDOFF - 1;
                end
            end else if (m_cnt[k] != 0) begin
                m_cnt[k] = m_cnt[k] - 1;
            end else if (m_env[k] < (hi >> 1)) begin
                m_hold[k] = 1'b0;
            end
            if (k == 0) exp0.push_back(e);
            else        exp1.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        int budget = 6 * fifo.size() + 200;
        while ((fifo.size() != 0 || exp0.size() != 0 || exp1.size() != 0) && n < budget) begin
            @(negedge CLOCK_50);
            n++;
        end
        check({name, "_drained"}, 32'(n < budget), 32'd1);
        repeat (6) @(negedge CLOCK_50);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        model_reset();
        reset = 1'b0;
        @(negedge CLOCK_50);
    endtask

    task automatic clear_counts();
        hits0 = 0; hits1 = 0; sv_idx = 0; hit_idx = -1;
    endtask

    // FIFO model: pop lands one cycle after read is seen, the non-empty flag lags by a cycle.
    initial begin : fifo_model
        smp_t s;
        audio_in_available     = 1'b0;
        left_channel_audio_in  = 32'd0;
        right_channel_audio_in = 32'd0;
        forever begin
            @(negedge CLOCK_50);
            if (pop_pend) begin
                if (fifo.size() == 0) check("pop_empty", 32'd0, 32'd1);
                else s = fifo.pop_front();
            end
            if (rd0 || rd1) begin
                check("rd_lockstep", 32'(rd1), 32'(rd0));
                if (rd0) begin
                    check("pop_gap", 32'((cyc - last_pop) >= 4), 32'd1);
                    last_pop = cyc;
                    pops++;
                end
            end
            pop_pend           = rd0;
            audio_in_available = flag_q;
            flag_q             = (fifo.size() != 0);
            left_channel_audio_in  = (fifo.size() != 0) ? fifo[0].l : 32'd0;
            right_channel_audio_in = (fifo.size() != 0) ? fifo[0].r : 32'd0;
        end
    end

    // Scoreboard monitor.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLOCK_50);
            if (hit0) check("hit0_with_valid", 32'(sv0), 32'd1);
            if (hit1) check("hit1_with_valid", 32'(sv1), 32'd1);
            if (sv0 || sv1) check("valid_lockstep", 32'(sv1), 32'(sv0));
            if (sv0) begin
                svs++;
                if (exp0.size() == 0) check("sb0_unexpected", 32'(exp0.size()), 32'd1);
                else begin
                    e = exp0.pop_front();
                    check("env0", env0, e.env);
                    check("hit0", 32'(hit0), 32'(e.hit));
                    check("level0", 32'(lvl0), 32'(e.env[30:27]));
                end
                if (decr_mode) check("env_decreasing", 32'(env0 < prev_env), 32'd1);
                prev_env = env0;
                if (hit0) begin
                    hits0++;
                    hit_idx = sv_idx;
                end
                sv_idx++;
            end
            if (sv1) begin
                if (exp1.size() == 0) check("sb1_unexpected", 32'(exp1.size()), 32'd1);
                else begin
                    e = exp1.pop_front();
                    check("env1", env1, e.env);
                    check("hit1", 32'(hit1), 32'(e.hit));
                    check("level1", 32'(lvl1), 32'(e.env[30:27]));
                end
                if (hit1) hits1++;
            end
        end
    end

    initial begin : stimulus
        real    r;
        longint lo, hi;
        int     p_before, s_before;

        // Reset held with three samples already waiting: nothing may be popped.
        reset      = 1'b1;
        thresh_sel = 4'd0;
        model_reset();
        @(negedge CLOCK_50);
        push(32'h0000_0100, 32'd0);
        push(32'h0000_0200, 32'd0);
        push(32'h0000_0300, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            check("rst_no_pop", 32'(rd0 | rd1), 32'd0);
        end
        check("rst_env", env0, 32'd0);
        check("rst_level", 32'(lvl0), 32'd0);
        check("rst_valid", 32'(sv0), 32'd0);
        check("rst_hit", 32'(hit0), 32'd0);
        reset = 1'b0;
        drain("t1");
        check("t1_pops", pops, 32'd3);
        check("t1_valids", svs, 32'd3);

        // Most negative sample saturates, then 64 silent samples decay by 63/64 each
        // (about 36.5% of full scale remains).
        do_reset();
        push(32'h8000_0000, 32'd0);
        drain("t2a");
        check("t2_env_sat", env0, 32'h7FFF_FFFF);
        check("t2_level", 32'(lvl0), 32'hF);
        decr_mode = 1'b1;
        for (int i = 0; i < 64; i++) push(32'd0, 32'd0);
        drain("t2b");
        decr_mode = 1'b0;
        r = 2147483647.0;
        for (int i = 0; i < 64; i++) r = r * 63.0 / 64.0;
        lo = longint'(r * 0.99);
        hi = longint'(r * 1.01);
        check("t2_decay64", 32'((longint'(env0) >= lo) && (longint'(env0) <= hi)), 32'd1);

        // Rising input crosses 0x0400_0000 on the fourth sample only.
        do_reset();
        thresh_sel = 4'd4;
        clear_counts();
        push(32'h0100_0000, 32'd0);
        push(32'h0200_0000, 32'd0);
        push(32'h03FF_FFFF, 32'd0);
        push(32'h0400_0000, 32'd0);
        drain("t3");
        check("t3_hits", hits0, 32'd1);
        check("t3_hit_index", hit_idx, 32'd3);
        check("t3_mix_hits", hits1, 32'd0);

        // Sustained loud input fires once; silence re-arms; a new strike fires again.
        do_reset();
        clear_counts();
        for (int i = 0; i < 10000; i++) push(32'h0400_0000, 32'd0);
        drain("t4a");
        check("t4_sustained_hits", hits0, 32'd1);
        for (int i = 0; i < 60; i++) push(32'd0, 32'd0);
        drain("t4b");
        check("t4_env_below_lo", 32'(env0 < 32'h0200_0000), 32'd1);
        push(32'h0400_0000, 32'd0);
        drain("t4c");
        check("t4_second_hit", hits0, 32'd2);
        check("t4_mix_hits", hits1, 32'd0);

        // Second strike inside the holdoff is ignored.
        do_reset();
        clear_counts();
        push(32'h7FFF_FFFF, 32'd0);
        for (int i = 0; i < 1999; i++) push(32'd0, 32'd0);
        push(32'h7FFF_FFFF, 32'd0);
        drain("t5a");
        check("t5_holdoff_hits", hits0, 32'd1);
        check("t5_mix_holdoff_hits", hits1, 32'd1);

        // Detection disabled: full scale never fires.
        do_reset();
        thresh_sel = 4'd0;
        clear_counts();
        for (int i = 0; i < 5; i++) push(32'h8000_0000, 32'h8000_0000);
        drain("t5b");
        check("t5_disabled_hits", hits0, 32'd0);
        check("t5_disabled_mix_hits", hits1, 32'd0);

        // L/R mix: half of each magnitude summed.
        do_reset();
        push(32'h4000_0000, 32'hC000_0000);
        drain("t6a");
        check("t6_mix_env", env1, 32'h4000_0000);

        // Back-to-back FIFO data: one pop per pass, none skipped or repeated.
        p_before = pops;
        s_before = svs;
        for (int i = 0; i < 8; i++) push(32'(i + 1) << 26, 32'd0 - (32'(i + 1) << 26));
        drain("t6b");
        check("t6_pops", pops - p_before, 32'd8);
        check("t6_valids", svs - s_before, 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
